// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock through
// a single full-subtractor cell, framed by a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;

  // Full-subtractor cell on the operand LSBs.
  logic d_d, br_d;
  assign d_d  = a_q[0] ^ b_q[0] ^ br_q;
  assign br_d = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      zero    <= 1'b0;
    end else begin
      // Outputs are registered off the current state, so they trail it by one edge.
      busy <= (state_q == SHIFT);
      done <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            res_q   <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          res_q <= {d_d, res_q[WIDTH-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= DONE;
        end
        DONE: begin
          diff    <= res_q;
          bout    <= br_q;
          zero    <= (res_q == '0);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: vector table on WIDTH=4 and WIDTH=8
// instances plus reset, dropped-start and held-start sequences.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst;
  logic start4, start8, bin4, bin8;
  logic [3:0] a4, b4, diff4;
  logic [7:0] a8, b8, diff8;
  logic busy4, done4, bout4, zero4;
  logic busy8, done8, bout8, zero8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4));

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8));

  typedef struct {
    bit       w8;
    bit [7:0] a;
    bit [7:0] b;
    bit       bin;
    bit [7:0] diff;
    bit       bout;
    bit       zero;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Outputs of whichever instance is under test.
  bit sel;
  logic o_busy, o_done, o_bout, o_zero;
  logic [7:0] o_diff;
  always_comb begin
    o_busy = sel ? busy8 : busy4;
    o_done = sel ? done8 : done4;
    o_bout = sel ? bout8 : bout4;
    o_zero = sel ? zero8 : zero4;
    o_diff = sel ? diff8 : {4'b0, diff4};
  end

  task automatic run_vec(input vec_t v);
    int w;
    w = v.w8 ? 8 : 4;
    sel = v.w8;
    @(negedge clk);
    if (v.w8) begin a8 = v.a; b8 = v.b; bin8 = v.bin; start8 = 1'b1; end
    else begin a4 = v.a[3:0]; b4 = v.b[3:0]; bin4 = v.bin; start4 = 1'b1; end
    @(negedge clk);  // edge 0 has accepted start; scramble the inputs
    start4 = 1'b0; start8 = 1'b0;
    a4 = ~a4; b4 = b4 + 4'd3; bin4 = ~bin4;
    a8 = ~a8; b8 = b8 + 8'd3; bin8 = ~bin8;
    for (int k = 1; k <= w; k++) begin
      @(negedge clk);
      chk($sformatf("busy_e%0d", k), o_busy, 1);
      chk($sformatf("nodone_e%0d", k), o_done, 0);
    end
    @(negedge clk);
    chk("done_pulse", o_done, 1);
    chk("busy_at_done", o_busy, 0);
    chk("diff", o_diff, v.diff);
    chk("bout", o_bout, v.bout);
    chk("zero", o_zero, v.zero);
    @(negedge clk);
    chk("done_single", o_done, 0);
    chk("diff_hold", o_diff, v.diff);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy4"}, busy4, 0); chk({tag, "_done4"}, done4, 0);
    chk({tag, "_diff4"}, diff4, 0); chk({tag, "_bout4"}, bout4, 0);
    chk({tag, "_zero4"}, zero4, 0); chk({tag, "_busy8"}, busy8, 0);
    chk({tag, "_diff8"}, diff8, 0); chk({tag, "_bout8"}, bout8, 0);
  endtask

  vec_t vecs[10];

  initial begin
    int ndone, last_t, t;
    logic [3:0] held;
    vecs[0] = '{0, 8'd9,   8'd3,  0, 8'd6,   0, 0};
    vecs[1] = '{0, 8'd3,   8'd9,  0, 8'd10,  1, 0};
    vecs[2] = '{0, 8'd5,   8'd5,  0, 8'd0,   0, 1};
    vecs[3] = '{0, 8'd0,   8'd0,  1, 8'd15,  1, 0};
    vecs[4] = '{0, 8'd15,  8'd0,  1, 8'd14,  0, 0};
    vecs[5] = '{0, 8'd7,   8'd7,  1, 8'd15,  1, 0};
    vecs[6] = '{0, 8'd0,   8'd15, 0, 8'd1,   1, 0};
    vecs[7] = '{1, 8'd0,   8'd0,  1, 8'd255, 1, 0};
    vecs[8] = '{1, 8'd200, 8'd55, 0, 8'd145, 0, 0};
    vecs[9] = '{1, 8'd10,  8'd20, 1, 8'd245, 1, 0};

    sel = 0;
    rst = 1'b1; start4 = 0; start8 = 0;
    a4 = 0; b4 = 0; bin4 = 0; a8 = 0; b8 = 0; bin8 = 0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Idle reset with nonzero held results; start high alongside must be ignored.
    @(negedge clk);
    rst = 1'b1; start4 = 1'b1; a4 = 4'd9; b4 = 4'd3;
    @(negedge clk);
    chk_all_zero("idle_rst");
    @(negedge clk);
    rst = 1'b0; start4 = 1'b0;
    @(negedge clk);
    chk("rst_start_dropped", busy4, 0);

    // Reset at SHIFT bit 2 aborts the op with no done pulse.
    sel = 0;
    @(negedge clk); a4 = 4'd9; b4 = 4'd3; bin4 = 0; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk_all_zero("shift_rst");
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_vec(vecs[0]);

    // Start pulsed during SHIFT is dropped.
    @(negedge clk); a4 = 4'd7; b4 = 4'd2; bin4 = 0; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0; a4 = 4'd1; b4 = 4'd14;
    @(negedge clk);
    @(negedge clk); start4 = 1'b1; a4 = 4'd12; b4 = 4'd4;
    @(negedge clk); start4 = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (done4) begin
        ndone++;
        chk("abuse_diff", diff4, 5);
        chk("abuse_bout", bout4, 0);
      end
      @(negedge clk);
    end
    chk("abuse_one_done", ndone, 1);

    // Start held high: back-to-back ops every WIDTH+2 cycles, outputs stable between.
    @(negedge clk); a4 = 4'd12; b4 = 4'd4; bin4 = 0; start4 = 1'b1;
    ndone = 0; last_t = -1; held = diff4;
    t = 0;
    while (ndone < 4 && t < 60) begin
      @(negedge clk);
      t++;
      if (done4) begin
        chk("held_diff", diff4, 8);
        chk("held_busy", busy4, 0);
        if (last_t >= 0) chk("held_spacing", t - last_t, 6);
        last_t = t; ndone++; held = diff4;
      end else if (ndone > 0) begin
        chk("held_stable", diff4, held);
      end
    end
    chk("held_count", ndone, 4);
    start4 = 1'b0;
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Handshake invariants on every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy4 && done4) begin failures++; $display("FAIL busy_done_overlap4: both high, expected exclusive"); end
      if (busy8 && done8) begin failures++; $display("FAIL busy_done_overlap8: both high, expected exclusive"); end
    end
  end

  logic done4_prev = 1'b0;
  always @(negedge clk) begin
    if (done4 && done4_prev) begin failures++; $display("FAIL done_twice4: high 2 cycles, expected 1"); end
    done4_prev <= done4;
  end
endmodule
